// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - start/pause/clear sequencer and tick prescaler for an enable-chained counter cascade
//
// Divides clk into a count tick for the first digit of a counter chain.
// Saturates in OVF rather than letting the chain wrap.
// Also keeps a lap-freeze flag for the display latch.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high; clears all state
//   start_stop     pulse: start / pause / resume
//   clear          pulse: back to IDLE, zero the chain
//   lap            pulse: toggle lap_freeze while RUN or PAUSE
//   chain_max      high when every digit of the chain is at its maximum
//   cnt_tick       registered one-cycle increment enable for the first digit
//   cnt_soft_reset registered one-cycle synchronous clear for every digit
//   state          IDLE=0, RUN=1, PAUSE=2, OVF=3
//   running        state == RUN
//   overflow       sticky, set on entry to OVF
//   lap_freeze     display latch hold
module stopwatch_ctrl #(
   parameter int DIV = 50000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       lap,
   input  logic       chain_max,
   output logic       cnt_tick,
   output logic       cnt_soft_reset,
   output logic [1:0] state,
   output logic       running,
   output logic       overflow,
   output logic       lap_freeze
);

   localparam int PW = $clog2(DIV);
   localparam logic [PW-1:0] P_MAX = PW'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      OVF   = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] p_q, p_d;
   logic          cnt_tick_q, cnt_tick_d;
   logic          cnt_soft_reset_q, cnt_soft_reset_d;
   logic          overflow_q, overflow_d;
   logic          lap_freeze_q, lap_freeze_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         p_q              <= '0;
         cnt_tick_q       <= 1'b0;
         cnt_soft_reset_q <= 1'b0;
         overflow_q       <= 1'b0;
         lap_freeze_q     <= 1'b0;
      end else begin
         state_q          <= state_d;
         p_q              <= p_d;
         cnt_tick_q       <= cnt_tick_d;
         cnt_soft_reset_q <= cnt_soft_reset_d;
         overflow_q       <= overflow_d;
         lap_freeze_q     <= lap_freeze_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      p_d              = p_q;
      cnt_tick_d       = 1'b0;
      cnt_soft_reset_d = 1'b0;
      overflow_d       = overflow_q;
      lap_freeze_d     = lap_freeze_q;

      if (clear) begin
         state_d          = IDLE;
         p_d              = '0;
         overflow_d       = 1'b0;
         lap_freeze_d     = 1'b0;
         cnt_soft_reset_d = 1'b1;
      end else if (start_stop) begin
         // The prescaler is held on a pause edge. A pause taken at p==DIV-1
         // therefore leaves the terminal count pending for the first RUN
         // cycle after resume.
         unique case (state_q)
            IDLE: begin
               state_d = RUN;
               p_d     = '0;
            end
            RUN:     state_d = PAUSE;
            PAUSE:   state_d = RUN;
            default: state_d = state_q;
         endcase
      end else begin
         if (state_q == RUN) begin
            if (p_q == P_MAX) begin
               p_d = '0;
               // Chain already at all-max: stop here instead of wrapping to zero.
               if (chain_max) begin
                  state_d    = OVF;
                  overflow_d = 1'b1;
               end else begin
                  cnt_tick_d = 1'b1;
               end
            end else begin
               p_d = p_q + PW'(1);
            end
         end
         // lap has the lowest priority, but it still acts in a terminal-count cycle.
         if (lap && (state_q == RUN || state_q == PAUSE)) begin
            lap_freeze_d = ~lap_freeze_q;
         end
      end
   end

   assign cnt_tick       = cnt_tick_q;
   assign cnt_soft_reset = cnt_soft_reset_q;
   assign state          = state_q;
   assign running        = (state_q == RUN);
   assign overflow       = overflow_q;
   assign lap_freeze     = lap_freeze_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

   logic       clk;
   logic       reset;
   logic       start_stop;
   logic       clear;
   logic       lap;
   logic       chain_max;
   logic       cnt_tick;
   logic       cnt_soft_reset;
   logic [1:0] state;
   logic       running;
   logic       overflow;
   logic       lap_freeze;

   int n_checks;
   int n_fail;
   int ticks;

   stopwatch_ctrl #(.DIV(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .start_stop     (start_stop),
      .clear          (clear),
      .lap            (lap),
      .chain_max      (chain_max),
      .cnt_tick       (cnt_tick),
      .cnt_soft_reset (cnt_soft_reset),
      .state          (state),
      .running        (running),
      .overflow       (overflow),
      .lap_freeze     (lap_freeze)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start_stop = 1'b1;
      step();
      start_stop = 1'b0;
   endtask

   task automatic pulse_lap();
      lap = 1'b1;
      step();
      lap = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      reset      = 1'b1;
      start_stop = 1'b0;
      clear      = 1'b0;
      lap        = 1'b0;
      chain_max  = 1'b0;
      step();
      step();

      // Reset state
      check("rst_state", state, 0);
      check("rst_tick", cnt_tick, 0);
      check("rst_sreset", cnt_soft_reset, 0);
      check("rst_ovf", overflow, 0);
      check("rst_lap", lap_freeze, 0);
      check("rst_running", running, 0);
      reset = 1'b0;

      // Ticks follow edges k+4, k+8 and k+12
      pulse_start();
      check("start_state", state, 1);
      check("start_running", running, 1);
      check("start_tick", cnt_tick, 0);
      ticks = 0;
      for (int j = 1; j <= 13; j++) begin
         step();
         check($sformatf("tick_seq%0d", j), cnt_tick, (j == 4 || j == 8 || j == 12) ? 1 : 0);
         if (cnt_tick) ticks++;
      end
      check("tick_count13", ticks, 3);

      // p is 1 here; one more edge makes it 2, then pause
      step();
      pulse_start();
      check("pause_state", state, 2);
      check("pause_running", running, 0);
      ticks = 0;
      for (int j = 0; j < 20; j++) begin
         step();
         if (cnt_tick) ticks++;
      end
      check("pause_no_tick", ticks, 0);

      // Resume at edge m: p=3 after m+1, tick after m+2
      pulse_start();
      check("resume_state", state, 1);
      check("resume_tick_m", cnt_tick, 0);
      step();
      check("resume_tick_m1", cnt_tick, 0);
      step();
      check("resume_tick_m2", cnt_tick, 1);
      step();
      check("resume_tick_m3", cnt_tick, 0);

      // Lap toggles in RUN, ticks keep coming (p=1 now)
      pulse_lap();
      check("lap_on", lap_freeze, 1);
      ticks = 0;
      for (int j = 0; j < 8; j++) begin
         step();
         if (cnt_tick) ticks++;
      end
      check("lap_ticks", ticks, 2);
      pulse_lap();
      check("lap_off", lap_freeze, 0);

      // p is 3: clear + start_stop together beats both pause and the tick
      lap        = 1'b1;
      start_stop = 1'b1;
      pulse_clear();
      start_stop = 1'b0;
      lap        = 1'b0;
      check("clr_ss_state", state, 0);
      check("clr_ss_sreset", cnt_soft_reset, 1);
      check("clr_ss_tick", cnt_tick, 0);
      check("clr_ss_lap", lap_freeze, 0);
      step();
      check("clr_ss_sreset_off", cnt_soft_reset, 0);
      check("clr_ss_tick2", cnt_tick, 0);
      ticks = 0;
      for (int j = 0; j < 8; j++) begin
         step();
         if (cnt_tick) ticks++;
      end
      check("idle_no_tick", ticks, 0);
      pulse_lap();
      check("idle_lap", lap_freeze, 0);

      // Clear in IDLE still pulses soft reset
      pulse_clear();
      check("idle_clr_sreset", cnt_soft_reset, 1);
      step();
      check("idle_clr_sreset_off", cnt_soft_reset, 0);

      // Overflow: chain_max high at terminal count
      pulse_start();
      pulse_lap();
      check("ovf_pre_lap", lap_freeze, 1);
      step();
      step();
      chain_max = 1'b1;
      step();
      check("ovf_tick", cnt_tick, 0);
      check("ovf_state", state, 3);
      check("ovf_flag", overflow, 1);
      check("ovf_running", running, 0);
      chain_max = 1'b0;
      step();
      check("ovf_tick2", cnt_tick, 0);
      pulse_start();
      check("ovf_ss_ignored", state, 3);
      pulse_lap();
      check("ovf_lap_held", lap_freeze, 1);
      pulse_clear();
      check("ovf_clr_state", state, 0);
      check("ovf_clr_flag", overflow, 0);
      check("ovf_clr_lap", lap_freeze, 0);
      check("ovf_clr_sreset", cnt_soft_reset, 1);
      step();
      check("ovf_clr_sreset_off", cnt_soft_reset, 0);

      // Async reset mid-cycle in RUN with p=3
      pulse_start();
      pulse_lap();
      step();
      step();
      check("arst_pre_state", state, 1);
      #2;
      reset = 1'b1;
      #1;
      check("arst_state", state, 0);
      check("arst_running", running, 0);
      check("arst_lap", lap_freeze, 0);
      check("arst_tick", cnt_tick, 0);
      check("arst_sreset", cnt_soft_reset, 0);
      check("arst_ovf", overflow, 0);
      #2;
      reset = 1'b0;
      ticks = 0;
      for (int j = 0; j < 8; j++) begin
         step();
         if (cnt_tick) ticks++;
      end
      check("arst_no_tick", ticks, 0);
      check("arst_idle", state, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequencer for a cascade of counter_digit-style enable-chained counters, e.g. a stopwatch or BCD timer.
- Divides clk into a count tick and drives the chain's increment enable (cnt_tick) and synchronous clear (cnt_soft_reset).
- Runs a start/pause/clear state machine and saturates instead of wrapping when the whole chain is at maximum.
- Sits between debounced single-cycle button pulses and the counter chain. It also produces a lap-freeze flag for the display latch.

Parameters:
- DIV, 50000000, clk cycles per count tick; legal range DIV >= 2.
- PW, $clog2(DIV), prescaler width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start_stop  input  1  single-cycle pulse: start / pause / resume.
- clear  input  1  single-cycle pulse: return to IDLE and zero the chain.
- lap  input  1  single-cycle pulse: toggle lap_freeze.
- chain_max  input  1  AND of every digit's max_tick; high means the chain is at all-max.
- cnt_tick  output  1  registered one-cycle increment enable to the first digit's prev_tick.
- cnt_soft_reset  output  1  registered one-cycle pulse to every digit's soft_reset.
- state  output  2  IDLE=0, RUN=1, PAUSE=2, OVF=3.
- running  output  1  high when state==RUN.
- overflow  output  1  sticky; set on entry to OVF.
- lap_freeze  output  1  high means the display latch holds its value.

Behaviour:
- Reset (async): state=IDLE, p=0. All outputs are 0: cnt_tick, cnt_soft_reset, overflow, lap_freeze, running. The digits are reset by the same reset line, so no cnt_soft_reset is issued.
- Input priority when pulses coincide in one cycle: clear > start_stop > terminal event > lap. The exception is that lap is still evaluated in the same cycle as a terminal event.
- Prescaler p (PW bits):
  - Counts only in RUN: p <= (p==DIV-1) ? 0 : p+1.
  - Held in PAUSE, so a resume continues the partial period.
  - Forced to 0 by clear, by reset, and on the IDLE->RUN transition.
- Terminal event T = (state==RUN) && (p==DIV-1) && !clear && !start_stop.
  - If chain_max==0 on T: cnt_tick=1 in the following cycle only.
  - If chain_max==1 on T: cnt_tick stays 0 (no wrap), state->OVF, overflow<=1.
- cnt_tick is never high on two consecutive cycles. DIV>=2 guarantees chain_max has settled before the next T.
- State transitions:
  - IDLE: start_stop -> RUN (p=0).
  - RUN: start_stop -> PAUSE.
  - PAUSE: start_stop -> RUN.
  - OVF: start_stop ignored.
  - Any state: clear -> IDLE, with p<=0, overflow<=0, lap_freeze<=0, and cnt_soft_reset=1 for exactly the following cycle.
  - Clear in IDLE still pulses cnt_soft_reset.
- start_stop in the same cycle that p==DIV-1 in RUN: pause wins and no tick is issued. p holds DIV-1, so T fires on the first RUN cycle after resume, provided neither clear nor start_stop is asserted in that cycle.
- lap:
  - In RUN or PAUSE: toggles lap_freeze.
  - In IDLE or OVF: ignored. lap_freeze is held in OVF and cleared only by clear or reset.
- running is a combinational decode of the state register. All other outputs are registered.
- Reset mid-RUN: immediate return to IDLE. A cnt_tick that is in flight is dropped.

Test Plan:
- DIV=4, chain_max=0, start_stop pulse sampled at edge k -> state=RUN after edge k. cnt_tick is high for one cycle after edges k+4, k+8, k+12; 3 ticks in 13 cycles.
- RUN with p at 2, start_stop pulse -> PAUSE, no tick for 20 cycles, p stays 2. A second start_stop at edge m (resumes, p stays 2) -> first cnt_tick after edge m+2, since p reaches 3 at edge m+1 and T fires at m+2.
- RUN with chain_max=1 when p==DIV-1 -> no cnt_tick, state=3, overflow=1. A further start_stop leaves state=3. Then clear -> state=0, overflow=0, cnt_soft_reset exactly one cycle.
- RUN, clear and start_stop in the same cycle -> state=IDLE (not PAUSE), cnt_soft_reset one cycle, p=0, no cnt_tick.
- RUN: lap -> lap_freeze=1; ticks continue every 4 cycles; lap again -> 0. In IDLE, lap leaves lap_freeze=0.
- Async reset asserted mid-cycle during RUN with p=3 -> outputs 0 and state=0 immediately. No tick after reset deasserts until start_stop.
